// File: rtl/vga_plot_sink_pkg.sv
// Shared screen geometry, FSM state encoding and the queued-pixel record for vga_plot_sink.
// The FIFO entry keeps the default 8/7/3-bit coordinate and colour widths.
package vga_plot_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int FB_WORDS  = 19200;
    localparam int FB_ADDR_W = 15;

    localparam int PX_W = 8;
    localparam int PY_W = 7;
    localparam int PC_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_e;

    typedef struct packed {
        logic [PX_W-1:0] x;
        logic [PY_W-1:0] y;
        logic [PC_W-1:0] colour;
    } plot_t;

    // y*160 + x as two shifts and adds, truncated to the word-address width
    function automatic logic [FB_ADDR_W-1:0] fb_addr_of(input plot_t p);
        logic [FB_ADDR_W-1:0] yy;
        logic [FB_ADDR_W-1:0] xx;
        yy = FB_ADDR_W'(p.y);
        xx = FB_ADDR_W'(p.x);
        return (yy << 7) + (yy << 5) + xx;
    endfunction

    function automatic logic in_range(input plot_t p);
        return (p.x < PX_W'(SCREEN_W)) && (p.y < PY_W'(SCREEN_H));
    endfunction

endpackage

// File: rtl/vga_plot_sink_if.sv
// Pixel-plot request signals plus the frame-buffer write handshake.
// master = lab logic / memory side, slave = vga_plot_sink.
interface vga_plot_sink_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int C_W = 3
);
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
    logic           plot;
    logic           clear;
    logic           fb_we;
    logic [14:0]    fb_addr;
    logic [C_W-1:0] fb_data;
    logic           fb_ready;

    modport master (
        output x, y, colour, plot, clear, fb_ready,
        input  fb_we, fb_addr, fb_data
    );

    modport slave (
        input  x, y, colour, plot, clear, fb_ready,
        output fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/vga_plot_sink_fifo.sv
// Synchronous FIFO of plot_t with simultaneous push/pop; exposes the head and the entry behind it
// so the sink can reload its output register on the same cycle it pops.
module plot_fifo
    import vga_plot_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  plot_t                    din_i,
    output plot_t                    head_o,
    output plot_t                    next_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    plot_t         mem_q [DEPTH];
    logic [AW:0]   wr_q;
    logic [AW:0]   rd_q;
    logic [AW-1:0] rd_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + (AW+1)'(1);
            if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
    end

    assign rd_nx   = rd_q[AW-1:0] + AW'(1);
    assign head_o  = mem_q[rd_q[AW-1:0]];
    assign next_o  = mem_q[rd_nx];
    assign count_o = wr_q - rd_q;
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (wr_q == rd_q);
endmodule

// File: rtl/vga_plot_sink.sv
// Queues plot pulses and drains them, or a full-screen clear, into the frame-buffer write port.
// Define PLOT_SINK_OOB_CLIP_EN to discard off-screen pixels at the FIFO input and flag them on oob.
//
// state | meaning
// IDLE  | no write presented; waits for clear or a queued pixel
// DRAIN | FIFO head presented on fb_*; popped when the write is accepted
// CLEAR | writes colour 0 to every address 0..19199
module vga_plot_sink
    import vga_plot_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int C_W        = 3
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    vga_plot_sink_if.slave       bus,
    output logic                 busy,
    output logic                 overflow,
    output logic                 oob
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [X_W-1:0] x_in;
    logic [Y_W-1:0] y_in;
    logic [C_W-1:0] c_in;
    plot_t          plot_in;
    plot_t          head;
    plot_t          next_head;
    logic [CW-1:0]  count;
    logic           full, empty, in_ok, xfer, push, pop;

    state_e                 state_q, state_d;
    logic                   fb_we_q, fb_we_d;
    logic [FB_ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic [C_W-1:0]         fb_data_q, fb_data_d;
    logic                   pend_q, pend_d;
    logic                   overflow_q, overflow_d;

    assign x_in    = bus.x;
    assign y_in    = bus.y;
    assign c_in    = bus.colour;
    assign plot_in = '{x: PX_W'(x_in), y: PY_W'(y_in), colour: PC_W'(c_in)};

`ifdef PLOT_SINK_OOB_CLIP_EN
    logic oob_q;
    assign in_ok = in_range(plot_in);
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)                     oob_q <= 1'b0;
        else if (bus.plot && !in_ok)     oob_q <= 1'b1;
    end
    assign oob = oob_q;
`else
    assign in_ok = 1'b1;
    assign oob   = 1'b0;
`endif

    assign xfer       = fb_we_q && bus.fb_ready;
    assign pop        = (state_q == DRAIN) && xfer;
    assign push       = bus.plot && in_ok && (!full || pop);
    assign overflow_d = overflow_q | (bus.plot && in_ok && full && !pop);

    plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (CLOCK_50),
        .rst_n   (resetn),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (plot_in),
        .head_o  (head),
        .next_o  (next_head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d   = state_q;
        fb_we_d   = fb_we_q;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        pend_d    = pend_q;
        case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    state_d   = CLEAR;
                    fb_we_d   = 1'b1;
                    fb_addr_d = '0;
                    fb_data_d = '0;
                end else if (!empty) begin
                    state_d   = DRAIN;
                    fb_we_d   = 1'b1;
                    fb_addr_d = fb_addr_of(head);
                    fb_data_d = C_W'(head.colour);
                end
            end
            DRAIN: begin
                if (bus.clear) pend_d = 1'b1;
                if (xfer) begin
                    if (pend_q || bus.clear) begin
                        state_d   = CLEAR;
                        pend_d    = 1'b0;
                        fb_addr_d = '0;
                        fb_data_d = '0;
                    end else if (count > CW'(1)) begin
                        fb_addr_d = fb_addr_of(next_head);
                        fb_data_d = C_W'(next_head.colour);
                    end else if (push) begin
                        // last entry leaving while a new one arrives: bypass the FIFO
                        fb_addr_d = fb_addr_of(plot_in);
                        fb_data_d = C_W'(plot_in.colour);
                    end else begin
                        state_d   = IDLE;
                        fb_we_d   = 1'b0;
                        fb_addr_d = '0;
                        fb_data_d = '0;
                    end
                end
            end
            CLEAR: begin
                // fb_addr_q doubles as the clear address counter
                if (bus.clear) begin
                    fb_addr_d = '0;
                end else if (xfer) begin
                    if (fb_addr_q == FB_ADDR_W'(FB_WORDS - 1)) begin
                        if (!empty) begin
                            state_d   = DRAIN;
                            fb_addr_d = fb_addr_of(head);
                            fb_data_d = C_W'(head.colour);
                        end else begin
                            state_d   = IDLE;
                            fb_we_d   = 1'b0;
                            fb_addr_d = '0;
                        end
                    end else begin
                        fb_addr_d = fb_addr_q + FB_ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                fb_we_d   = 1'b0;
                fb_addr_d = '0;
                fb_data_d = '0;
                pend_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            pend_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.fb_we   = fb_we_q;
    assign bus.fb_addr = fb_addr_q;
    assign bus.fb_data = fb_data_q;
    assign busy        = (state_q != IDLE) || !empty;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_vga_plot_sink.sv
// Directed bench for vga_plot_sink: latency, overflow/stall, clear, full-FIFO push/pop, range check, reset.
module tb_vga_plot_sink;
    logic clk;
    logic resetn;
    logic busy, overflow, oob;
    int   errors = 0;
    int   checks = 0;
    int   exp_a [10];
    int   exp_c [10];
    int   bad;

    vga_plot_sink_if #(.X_W(8), .Y_W(7), .C_W(3)) bus ();

    vga_plot_sink #(.FIFO_DEPTH(8), .X_W(8), .Y_W(7), .C_W(3)) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus),
        .busy     (busy),
        .overflow (overflow),
        .oob      (oob)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_plot(input int px, input int py, input int pc);
        bus.x      = 8'(px);
        bus.y      = 7'(py);
        bus.colour = 3'(pc);
        bus.plot   = 1'b1;
    endtask

    initial begin
        resetn       = 1'b0;
        bus.x        = '0;
        bus.y        = '0;
        bus.colour   = '0;
        bus.plot     = 1'b0;
        bus.clear    = 1'b0;
        bus.fb_ready = 1'b0;
        #1;
        chk("reset_we",   bus.fb_we, 0);
        chk("reset_addr", bus.fb_addr, 0);
        chk("reset_data", bus.fb_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ovf",  overflow, 0);
        chk("reset_oob",  oob, 0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // 1: single plot latency
        bus.fb_ready = 1'b1;
        drive_plot(3, 2, 5);
        tick();
        bus.plot = 1'b0;
        chk("t1_we_n1",   bus.fb_we, 0);
        chk("t1_busy_n1", busy, 1);
        tick();
        chk("t1_we_n2",   bus.fb_we, 1);
        chk("t1_addr",    bus.fb_addr, 323);
        chk("t1_data",    bus.fb_data, 5);
        tick();
        chk("t1_we_done", bus.fb_we, 0);
        chk("t1_busy_done", busy, 0);

        // 2: ten plots into a stalled sink
        bus.fb_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_a[i] = i * 160 + 10 + i;
            exp_c[i] = i % 8;
            drive_plot(10 + i, i, i % 8);
            if (i == 8) chk("t2_ovf_before", overflow, 0);
            if (i == 9) chk("t2_ovf_rise",   overflow, 1);
            tick();
        end
        bus.plot = 1'b0;
        chk("t2_ovf", overflow, 1);
        for (int i = 0; i < 8; i++) begin
            bus.fb_ready = 1'b0;
            chk("t2_we",   bus.fb_we, 1);
            chk("t2_addr", bus.fb_addr, exp_a[i]);
            chk("t2_data", bus.fb_data, exp_c[i]);
            tick();
            chk("t2_addr_stall", bus.fb_addr, exp_a[i]);
            bus.fb_ready = 1'b1;
            tick();
        end
        chk("t2_we_end",   bus.fb_we, 0);
        chk("t2_busy_end", busy, 0);

        // 3: full clear with a corner pixel plotted during it
        bus.fb_ready = 1'b1;
        bus.clear    = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("t3_busy", busy, 1);
        bad = 0;
        for (int k = 0; k < 19200; k++) begin
            if (!(bus.fb_we === 1'b1 && bus.fb_addr === 15'(k) && bus.fb_data === 3'd0)) bad++;
            if (k == 5) drive_plot(159, 119, 6);
            else        bus.plot = 1'b0;
            tick();
        end
        chk("t3_clear_words", bad, 0);
        chk("t3_px_we",   bus.fb_we, 1);
        chk("t3_px_addr", bus.fb_addr, 19199);
        chk("t3_px_data", bus.fb_data, 6);
        tick();
        chk("t3_we_end", bus.fb_we, 0);
        chk("t3_busy_end", busy, 0);

        // 6: reset in the middle of a clear
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        for (int k = 0; k < 500; k++) tick();
        chk("t6_addr_500", bus.fb_addr, 500);
        resetn = 1'b0;
        #1;
        chk("t6_we",   bus.fb_we, 0);
        chk("t6_addr", bus.fb_addr, 0);
        chk("t6_data", bus.fb_data, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ovf",  overflow, 0);
        chk("t6_oob",  oob, 0);
        tick();
        resetn = 1'b1;
        tick();
        tick();
        chk("t6_busy_after", busy, 0);
        chk("t6_we_after",   bus.fb_we, 0);

        // 4: full FIFO, plot coincides with a pop
        bus.fb_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exp_a[i] = (3 + i) * 160 + 20 + i;
            exp_c[i] = (i + 1) % 8;
        end
        for (int i = 0; i < 8; i++) begin
            drive_plot(20 + i, 3 + i, (i + 1) % 8);
            tick();
        end
        drive_plot(28, 11, 1);
        bus.fb_ready = 1'b1;
        chk("t4_addr0", bus.fb_addr, exp_a[0]);
        tick();
        bus.plot = 1'b0;
        chk("t4_ovf", overflow, 0);
        for (int i = 1; i < 9; i++) begin
            chk("t4_we",   bus.fb_we, 1);
            chk("t4_addr", bus.fb_addr, exp_a[i]);
            chk("t4_data", bus.fb_data, exp_c[i]);
            tick();
        end
        chk("t4_we_end",  bus.fb_we, 0);
        chk("t4_ovf_end", overflow, 0);

        // 5: off-screen pixel
        drive_plot(200, 5, 2);
        tick();
        bus.plot = 1'b0;
`ifdef PLOT_SINK_OOB_CLIP_EN
        chk("t5_oob",  oob, 1);
        chk("t5_busy", busy, 0);
        tick();
        chk("t5_we", bus.fb_we, 0);
`else
        chk("t5_oob",  oob, 0);
        tick();
        chk("t5_we",   bus.fb_we, 1);
        chk("t5_addr", bus.fb_addr, 1000);
        chk("t5_data", bus.fb_data, 2);
`endif
        tick();
        chk("t5_we_end", bus.fb_we, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_plot_sink.md
# vga_plot_sink

Receiving end of the pixel-plot interface that `x`, `y`, `colour` and `plot` drive toward the VGA output. It captures every single-cycle `plot` pulse into a small FIFO and drains the FIFO into a 160×120, 3-bit frame-buffer write port using a valid/ready handshake. It also performs a full-screen clear on request. It sits between the lab logic and the frame-buffer memory of the VGA adapter.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: plot FIFO entries; must be a power of 2 and at least 2.
- `X_W`, default 8: x coordinate width.
- `Y_W`, default 7: y coordinate width.
- `C_W`, default 3: colour width.

Ports:
- `CLOCK_50`, in, 1: the single clock, 50 MHz; all state is on its rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `x`, in, `X_W`: pixel column.
- `y`, in, `Y_W`: pixel row.
- `colour`, in, `C_W`: pixel colour.
- `plot`, in, 1: a 1-cycle pulse that writes (`x`, `y`, `colour`).
- `clear`, in, 1: a 1-cycle pulse that requests a full-screen clear to colour 0.
- `fb_we`, out, 1: frame-buffer write valid.
- `fb_addr`, out, 15: frame-buffer word address.
- `fb_data`, out, `C_W`: frame-buffer write data.
- `fb_ready`, in, 1: memory accepts the write this cycle.
- `busy`, out, 1: high while clearing or while the FIFO is non-empty.
- `overflow`, out, 1: sticky; set when a `plot` arrives while the FIFO is full. Cleared only by reset.
- `oob`, out, 1: sticky; set when an out-of-range pixel is discarded. Cleared only by reset.

## Operation
- **Reset values.** All outputs are 0. The FIFO is empty and the FSM is in IDLE.
- **Address arithmetic.** `fb_addr = y*160 + x`, implemented as `(y<<7)+(y<<5)+x` in 15 bits. The maximum legal value is 19199.
- **FIFO push.** A push occurs on `plot` when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - A `plot` into a full FIFO with no simultaneous pop is dropped and sets `overflow`.
- **Write transfer.** A transfer completes when `fb_we && fb_ready`.
  - `fb_addr` and `fb_data` stay stable while `fb_we` is high and `fb_ready` is low.
- **FSM states:**
  - IDLE: `fb_we`=0. Go to CLEAR if `clear` is high. Otherwise go to DRAIN if the FIFO is non-empty.
  - DRAIN: present the FIFO head registered on `fb_*`. Pop on transfer. Return to IDLE when the FIFO is empty after the pop. A `clear` seen here is latched as pending and taken after the current transfer completes.
  - CLEAR: counter `clr_addr` runs from 0 to 19199. `fb_data`=0 and `fb_we`=1. The counter increments on each transfer. After the transfer at 19199, go to DRAIN if the FIFO is non-empty, else IDLE.
- **Priority.** Clear outranks queued plots. Plots that arrive during a clear are queued and drawn after it, so they are not erased.
- **Repeated clear.** A `clear` arriving while already in CLEAR restarts the counter at 0.
- **Reset mid-operation.** Reset aborts the clear or drain immediately. The FIFO and both sticky flags are lost.

## Timing
- **Latency.** A `plot` in cycle N, with the FIFO empty and the FSM in IDLE, gives `fb_we`=1 with that pixel in cycle N+2 (FIFO write, then FSM registering it).
- **Throughput.** One write per cycle while `fb_ready` is held at 1. There are no bubbles between consecutive DRAIN writes.
- **Clear duration.** A clear takes exactly 19200 cycles with `fb_ready` held high, plus 1 cycle of entry.
- **`busy` timing.** `busy` rises the cycle after the `plot` or `clear` that causes it. It falls in the cycle after the last transfer.
- **Flag timing.** Both sticky flags are registered and rise one cycle after the triggering event.

## Configuration
- `PLOT_SINK_OOB_CLIP_EN` defined: pixels with x>159 or y>119 are discarded at the FIFO input. They are not pushed and they set `oob`.
- `PLOT_SINK_OOB_CLIP_EN` undefined: there is no range check. The address is truncated to 15 bits, and `oob` is tied to 0.

## Structure
- **Package `vga_plot_pkg`.** Holds these shared items:
  - `SCREEN_W`=160 and `SCREEN_H`=120.
  - `FB_WORDS`=19200 and `FB_ADDR_W`=15.
  - The state enum (IDLE, DRAIN, CLEAR).
  - The packed struct `plot_t` {x, y, colour}.
- **Sub-module `plot_fifo`.** A synchronous FIFO of `plot_t` with push, pop, full, empty and simultaneous push/pop support. It is instantiated once.

## Test plan
1. Reset, then `plot` with x=3, y=2, colour=5 and `fb_ready`=1 → `fb_we` in cycle N+2 with `fb_addr`=323 and `fb_data`=5; `busy` falls afterwards.
2. 10 back-to-back plots with `fb_ready`=0 and `FIFO_DEPTH`=8 → `overflow`=1; after raising `fb_ready`, exactly 8 writes appear in order with addresses unchanged across stalls.
3. `clear` pulse with `fb_ready`=1 → 19200 writes, addresses 0..19199, data 0; a plot at x=159, y=119 during the clear is written after them with address 19199.
4. Full FIFO with simultaneous `plot` and pop → no overflow, and the new entry is written last.
5. With `PLOT_SINK_OOB_CLIP_EN` defined, `plot` at x=200, y=5 → no write and `oob`=1.
6. Assert `resetn`=0 mid-clear at address 500 → all outputs 0 immediately; after release the FSM is in IDLE and `busy`=0.
